// File: rtl/lcd_win_pkg.sv
// Shared definitions for the LCD window processor: command codes, FSM state
// encodings, window geometry and the clockwise ring ordering used by ROT.
package lcd_win_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE   = 4'd0,
    CMD_UP      = 4'd1,
    CMD_DOWN    = 4'd2,
    CMD_LEFT    = 4'd3,
    CMD_RIGHT   = 4'd4,
    CMD_MAX     = 4'd5,
    CMD_MIN     = 4'd6,
    CMD_AVG     = 4'd7,
    CMD_WHITE   = 4'd8,
    CMD_BLACK   = 4'd9,
    CMD_ROT     = 4'd10,
    CMD_RESTORE = 4'd11,
    CMD_COPY    = 4'd12,
    CMD_PASTE   = 4'd13,
    CMD_RELOAD  = 4'd14,
    CMD_DONE    = 4'd15
  } cmd_e;

  localparam logic [2:0] ST_LOAD    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_OP      = 3'd3;
  localparam logic [2:0] ST_RESTORE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // Window pixels are numbered row-major 0..8, centre is 4.
  localparam int WIN_N  = 9;
  localparam int RING_N = 8;

  // Window index of ring position p, walking clockwise from the top-left corner:
  // TL, TM, TR, MR, BR, BM, BL, ML.
  function automatic logic [3:0] ringIdx(input logic [2:0] pos);
    logic [3:0] idx;
    case (pos)
      3'd0:    idx = 4'd0;
      3'd1:    idx = 4'd1;
      3'd2:    idx = 4'd2;
      3'd3:    idx = 4'd5;
      3'd4:    idx = 4'd8;
      3'd5:    idx = 4'd7;
      3'd6:    idx = 4'd6;
      default: idx = 4'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/lcd_win_stats.sv
// Combinational statistics over a 3x3 window: maximum, minimum and the
// floor of the mean. The sum carries four extra bits so nine full-scale
// pixels can never overflow it.
module lcd_win_stats
  import lcd_win_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] pix_i [WIN_N],
  output logic [DW-1:0] max_o,
  output logic [DW-1:0] min_o,
  output logic [DW-1:0] avg_o
);

  localparam logic [DW+3:0] NINE = (DW+4)'(WIN_N);

  logic [DW+3:0] sum;

  // Single pass over the nine pixels for both extremes and the running total
  always_comb begin
    max_o = pix_i[0];
    min_o = pix_i[0];
    sum   = '0;
    for (int j = 0; j < WIN_N; j++) begin
      if (pix_i[j] > max_o) max_o = pix_i[j];
      if (pix_i[j] < min_o) min_o = pix_i[j];
      sum = sum + {4'b0000, pix_i[j]};
    end
    avg_o = DW'(sum / NINE);
  end

endmodule

// File: rtl/lcd_win_proc.sv
// 3x3 window image processor for the LCD path. Loads a 2^XB x 2^YB image from
// IROM into a register store, then executes one command per handshake on the
// window centred at (x,y): cursor moves, window filters, ring rotation,
// copy/paste, full-image write to IRAM and window restore from IRAM.
module lcd_win_proc
  import lcd_win_pkg::*;
#(
  parameter int DW = 8,
  parameter int XB = 3,
  parameter int YB = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       cmd,
  input  logic             cmd_valid,
  output logic             busy,
  output logic             done,
  output logic             rom_rd,
  output logic [XB+YB-1:0] rom_a,
  input  logic [DW-1:0]    rom_q,
  output logic             ram_ce,
  output logic             ram_we,
  output logic [XB+YB-1:0] ram_a,
  output logic [DW-1:0]    ram_d,
  input  logic [DW-1:0]    ram_q
);

  localparam int AW = XB + YB;
  localparam int W  = 1 << XB;
  localparam int H  = 1 << YB;
  localparam int N  = 1 << AW;
  localparam int CW = AW + 1;

  localparam logic [XB-1:0] X_MIN = XB'(1);
  localparam logic [XB-1:0] X_MAX = XB'(W - 2);
  localparam logic [XB-1:0] X_RST = XB'(W / 2);
  localparam logic [YB-1:0] Y_MIN = YB'(1);
  localparam logic [YB-1:0] Y_MAX = YB'(H - 2);
  localparam logic [YB-1:0] Y_RST = YB'(H / 2);

  localparam logic [CW-1:0] CNT_N    = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_WIN  = CW'(WIN_N);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_e          cmd_q, cmd_d;
  logic [XB-1:0] posX_q, posX_d;
  logic [YB-1:0] posY_q, posY_d;

  logic [DW-1:0] pix_q     [N];
  logic [DW-1:0] copyBuf_q [WIN_N];

  logic [AW-1:0] winAddr [WIN_N];
  logic [DW-1:0] win     [WIN_N];
  logic [DW-1:0] winNew  [WIN_N];
  logic          winWe;

  logic [DW-1:0] statMax, statMin, statAvg;

  logic          loadWe, restWe;
  logic [AW-1:0] loadAddr;
  logic [3:0]    restSel, restRdSel;

  // Linear addresses and current contents of the nine window pixels; the
  // clamped centre keeps every neighbour inside the image, so no wrap occurs
  always_comb begin
    for (int j = 0; j < WIN_N; j++) begin
      winAddr[j] = {YB'(posY_q + YB'(j / 3) - YB'(1)),
                    XB'(posX_q + XB'(j % 3) - XB'(1))};
      win[j]     = pix_q[winAddr[j]];
    end
  end

  lcd_win_stats #(
    .DW(DW)
  ) u_stats (
    .pix_i(win),
    .max_o(statMax),
    .min_o(statMin),
    .avg_o(statAvg)
  );

  // New window contents for the single-cycle window-rewriting commands
  always_comb begin
    winWe = 1'b0;
    for (int j = 0; j < WIN_N; j++) winNew[j] = win[j];
    if (state_q == ST_OP) begin
      case (cmd_q)
        CMD_MAX: begin
          winWe = 1'b1;
          for (int j = 0; j < WIN_N; j++) winNew[j] = statMax;
        end
        CMD_MIN: begin
          winWe = 1'b1;
          for (int j = 0; j < WIN_N; j++) winNew[j] = statMin;
        end
        CMD_AVG: begin
          winWe = 1'b1;
          for (int j = 0; j < WIN_N; j++) winNew[j] = statAvg;
        end
        CMD_WHITE: begin
          winWe = 1'b1;
          for (int j = 0; j < WIN_N; j++) winNew[j] = '1;
        end
        CMD_BLACK: begin
          winWe = 1'b1;
          for (int j = 0; j < WIN_N; j++) winNew[j] = '0;
        end
        CMD_ROT: begin
          winWe = 1'b1;
          for (int i = 0; i < RING_N; i++)
            winNew[ringIdx(3'(i))] = win[ringIdx(3'(i + 7))];
        end
        CMD_PASTE: begin
          winWe = 1'b1;
          for (int j = 0; j < WIN_N; j++) winNew[j] = copyBuf_q[j];
        end
        default: ;
      endcase
    end
  end

  // Sequencing: load counter, command acceptance, multi-cycle op counters, cursor moves
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    posX_d  = posX_q;
    posY_d  = posY_q;
    case (state_q)
      ST_LOAD: begin
        if (cnt_q == CNT_N) begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CMD: begin
        if (cmd_valid) begin
          cmd_d = cmd_e'(cmd);
          cnt_d = '0;
          case (cmd_e'(cmd))
            CMD_WRITE:   state_d = ST_WRITE;
            CMD_RESTORE: state_d = ST_RESTORE;
            CMD_RELOAD:  state_d = ST_LOAD;
            CMD_DONE:    state_d = ST_DONE;
            default:     state_d = ST_OP;
          endcase
        end
      end
      ST_WRITE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESTORE: begin
        if (cnt_q == CNT_WIN) begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_OP: begin
        state_d = ST_CMD;
        case (cmd_q)
          CMD_UP:    if (posY_q > Y_MIN) posY_d = posY_q - YB'(1);
          CMD_DOWN:  if (posY_q < Y_MAX) posY_d = posY_q + YB'(1);
          CMD_LEFT:  if (posX_q > X_MIN) posX_d = posX_q - XB'(1);
          CMD_RIGHT: if (posX_q < X_MAX) posX_d = posX_q + XB'(1);
          default: ;
        endcase
      end
      ST_DONE: ;
      default: state_d = ST_LOAD;
    endcase
  end

  // Control registers; reset returns to a fresh load with the cursor centred
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      cmd_q   <= CMD_WRITE;
      posX_q  <= X_RST;
      posY_q  <= Y_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      posX_q  <= posX_d;
      posY_q  <= posY_d;
    end
  end

  // Memory read data arrives one cycle after its address, so the store
  // always writes the entry addressed on the previous count
  always_comb begin
    loadWe    = (state_q == ST_LOAD) && (cnt_q != '0);
    loadAddr  = AW'(cnt_q - CW'(1));
    restWe    = (state_q == ST_RESTORE) && (cnt_q != '0);
    restSel   = cnt_q[3:0] - 4'd1;
    restRdSel = (cnt_q < CNT_WIN) ? cnt_q[3:0] : 4'd0;
  end

  // Pixel store: filled by LOAD and RESTORE, rewritten by window commands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) pix_q[i] <= '0;
    end else if (loadWe) begin
      pix_q[loadAddr] <= rom_q;
    end else if (restWe) begin
      pix_q[winAddr[restSel]] <= ram_q;
    end else if (winWe) begin
      for (int j = 0; j < WIN_N; j++) pix_q[winAddr[j]] <= winNew[j];
    end
  end

  // Copy buffer survives RELOAD and only clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < WIN_N; j++) copyBuf_q[j] <= '0;
    end else if ((state_q == ST_OP) && (cmd_q == CMD_COPY)) begin
      for (int j = 0; j < WIN_N; j++) copyBuf_q[j] <= win[j];
    end
  end

  // Memory strobes decoded from state; rom_rd is masked by rst because the
  // reset state is LOAD and the strobe must stay low while reset is held
  always_comb begin
    busy   = (state_q != ST_CMD);
    done   = (state_q == ST_DONE);
    rom_rd = !rst && (state_q == ST_LOAD) && (cnt_q != CNT_N);
    rom_a  = rom_rd ? cnt_q[AW-1:0] : '0;
    ram_ce = 1'b0;
    ram_we = 1'b0;
    ram_a  = '0;
    ram_d  = '0;
    if (state_q == ST_WRITE) begin
      ram_ce = 1'b1;
      ram_we = 1'b1;
      ram_a  = cnt_q[AW-1:0];
      ram_d  = pix_q[cnt_q[AW-1:0]];
    end else if ((state_q == ST_RESTORE) && (cnt_q < CNT_WIN)) begin
      ram_ce = 1'b1;
      ram_a  = winAddr[restRdSel];
    end
  end

endmodule

// File: tb/tb_lcd_win_proc.sv
// Randomised scoreboard bench for lcd_win_proc. Stimulus drives commands and
// updates a plain array model of the image; expected IRAM writes, IRAM read
// addresses and IROM addresses are queued and checked by an independent
// monitor as the DUT presents them.
module tb_lcd_win_proc;

  localparam int DW = 8;
  localparam int XB = 3;
  localparam int YB = 3;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = 64;
  localparam int WAIT_LIMIT = 200;

  localparam int RDX [8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
  localparam int RDY [8] = '{-1, -1, -1, 0, 1, 1, 1, 0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    cmd = 4'd0;
  logic          cmd_valid = 1'b0;
  logic          busy, done, rom_rd, ram_ce, ram_we;
  logic [XB+YB-1:0] rom_a, ram_a;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] rom_q = '0;
  logic [DW-1:0] ram_q = '0;

  int romMem [N];
  int ramMem [N];

  int img [N];
  int refRam [N];
  int cbuf [9];
  int cx, cy;

  int wrAddrQ [$];
  int wrDataQ [$];
  int rdAddrQ [$];
  int romAddrQ [$];

  int total = 0;
  int bad   = 0;
  int ea, ed;

  lcd_win_proc #(
    .DW(DW),
    .XB(XB),
    .YB(YB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
    .busy(busy),
    .done(done),
    .rom_rd(rom_rd),
    .rom_a(rom_a),
    .rom_q(rom_q),
    .ram_ce(ram_ce),
    .ram_we(ram_we),
    .ram_a(ram_a),
    .ram_d(ram_d),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // IROM and IRAM behavioural memories with one-cycle read latency
  always @(posedge clk) begin
    if (rom_rd) rom_q <= DW'(romMem[rom_a]);
    if (ram_ce && ram_we) ramMem[ram_a] <= int'(ram_d);
    else if (ram_ce) ram_q <= DW'(ramMem[ram_a]);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every memory transaction the DUT presents against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_ce && ram_we) begin
        if (wrAddrQ.size() == 0) begin
          checkOutput("unexpected_ram_write", 1, 0);
        end else begin
          ea = wrAddrQ.pop_front();
          ed = wrDataQ.pop_front();
          checkOutput("ram_a_write", int'(ram_a), ea);
          checkOutput("ram_d", int'(ram_d), ed);
        end
      end else if (ram_ce) begin
        if (rdAddrQ.size() == 0) begin
          checkOutput("unexpected_ram_read", 1, 0);
        end else begin
          ea = rdAddrQ.pop_front();
          checkOutput("ram_a_read", int'(ram_a), ea);
        end
      end
      if (rom_rd) begin
        if (romAddrQ.size() == 0) begin
          checkOutput("unexpected_rom_read", 1, 0);
        end else begin
          ea = romAddrQ.pop_front();
          checkOutput("rom_a", int'(rom_a), ea);
        end
      end
    end
  end

  function automatic int wAddr(input int j);
    return (cy + j / 3 - 1) * W + (cx + j % 3 - 1);
  endfunction

  function automatic int expLat(input int c);
    case (c)
      0:       return N;
      11:      return 10;
      14:      return N + 1;
      default: return 1;
    endcase
  endfunction

  task automatic modelLoad();
    for (int k = 0; k < N; k++) begin
      romAddrQ.push_back(k);
      img[k] = romMem[k];
    end
  endtask

  task automatic modelReset();
    wrAddrQ.delete();
    wrDataQ.delete();
    rdAddrQ.delete();
    romAddrQ.delete();
    cx = W / 2;
    cy = H / 2;
    for (int j = 0; j < 9; j++) cbuf[j] = 0;
  endtask

  // Reference behaviour of each command on the abstract image
  task automatic modelApply(input int c);
    int m;
    int s;
    int old [8];
    case (c)
      0: for (int k = 0; k < N; k++) begin
           wrAddrQ.push_back(k);
           wrDataQ.push_back(img[k]);
           refRam[k] = img[k];
         end
      1: if (cy > 1) cy--;
      2: if (cy < H - 2) cy++;
      3: if (cx > 1) cx--;
      4: if (cx < W - 2) cx++;
      5: begin
           m = 0;
           for (int j = 0; j < 9; j++) if (img[wAddr(j)] > m) m = img[wAddr(j)];
           for (int j = 0; j < 9; j++) img[wAddr(j)] = m;
         end
      6: begin
           m = 255;
           for (int j = 0; j < 9; j++) if (img[wAddr(j)] < m) m = img[wAddr(j)];
           for (int j = 0; j < 9; j++) img[wAddr(j)] = m;
         end
      7: begin
           s = 0;
           for (int j = 0; j < 9; j++) s += img[wAddr(j)];
           for (int j = 0; j < 9; j++) img[wAddr(j)] = s / 9;
         end
      8: for (int j = 0; j < 9; j++) img[wAddr(j)] = 255;
      9: for (int j = 0; j < 9; j++) img[wAddr(j)] = 0;
      10: begin
           for (int i = 0; i < 8; i++) old[i] = img[(cy + RDY[i]) * W + cx + RDX[i]];
           for (int i = 0; i < 8; i++) img[(cy + RDY[i]) * W + cx + RDX[i]] = old[(i + 7) % 8];
         end
      11: for (int j = 0; j < 9; j++) begin
           rdAddrQ.push_back(wAddr(j));
           img[wAddr(j)] = refRam[wAddr(j)];
         end
      12: for (int j = 0; j < 9; j++) cbuf[j] = img[wAddr(j)];
      13: for (int j = 0; j < 9; j++) img[wAddr(j)] = cbuf[j];
      14: modelLoad();
      default: ;
    endcase
  endtask

  // Issue one command; optionally hold a stray cmd_valid (MAX) while busy
  task automatic applyStimulus(input int c, input bit junk);
    int cyc;
    modelApply(c);
    cmd = 4'(c);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (junk) begin
      cmd = 4'd5;
      cmd_valid = 1'b1;
    end else begin
      cmd_valid = 1'b0;
    end
    cyc = 0;
    while (busy && cyc < WAIT_LIMIT) begin
      cyc++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    checkOutput($sformatf("busy_cycles_cmd%0d", c), cyc, expLat(c));
  endtask

  task automatic checkResetValues();
    checkOutput("rst_busy", int'(busy), 1);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_rom_rd", int'(rom_rd), 0);
    checkOutput("rst_rom_a", int'(rom_a), 0);
    checkOutput("rst_ram_ce", int'(ram_ce), 0);
    checkOutput("rst_ram_we", int'(ram_we), 0);
    checkOutput("rst_ram_a", int'(ram_a), 0);
    checkOutput("rst_ram_d", int'(ram_d), 0);
  endtask

  task automatic waitLoad();
    int cyc;
    cyc = 0;
    while (busy && cyc < WAIT_LIMIT) begin
      cyc++;
      @(posedge clk); #1;
    end
    checkOutput("load_cycles", cyc, N + 1);
  endtask

  initial begin
    int c;
    bit junk;
    for (int k = 0; k < N; k++) begin
      romMem[k] = k;
      ramMem[k] = k;
      refRam[k] = k;
      img[k]    = 0;
    end
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkResetValues();
    modelLoad();
    rst = 1'b0;
    waitLoad();

    // Directed sequence on the ramp image
    applyStimulus(0, 1'b1);
    applyStimulus(7, 1'b0);
    applyStimulus(0, 1'b0);
    applyStimulus(9, 1'b0);
    applyStimulus(11, 1'b0);
    applyStimulus(0, 1'b0);
    applyStimulus(10, 1'b0);
    applyStimulus(0, 1'b0);
    applyStimulus(5, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(4, 1'b0);
    applyStimulus(8, 1'b0);
    applyStimulus(12, 1'b0);
    applyStimulus(3, 1'b1);
    applyStimulus(13, 1'b0);
    applyStimulus(0, 1'b0);

    // Randomised command stream
    for (int i = 0; i < 70; i++) begin
      c = int'($urandom_range(0, 14));
      junk = 1'($urandom_range(0, 1));
      if (c == 14) begin
        for (int k = 0; k < N; k++) romMem[k] = int'($urandom_range(0, 255));
      end
      applyStimulus(c, junk);
    end
    applyStimulus(0, 1'b0);

    // Reset in the middle of a reload
    for (int k = 0; k < N; k++) romMem[k] = int'($urandom_range(0, 255));
    modelApply(14);
    cmd = 4'd14;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkResetValues();
    modelReset();
    @(posedge clk); #1;
    modelLoad();
    rst = 1'b0;
    waitLoad();
    applyStimulus(13, 1'b0);
    applyStimulus(0, 1'b0);
    applyStimulus(11, 1'b0);
    applyStimulus(0, 1'b0);

    // DONE is terminal: busy and done stay high, further commands ignored
    cmd = 4'd15;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd = 4'd0;
    checkOutput("done_flag", int'(done), 1);
    checkOutput("done_busy", int'(busy), 1);
    repeat (10) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("done_flag_held", int'(done), 1);
    checkOutput("done_busy_held", int'(busy), 1);
    repeat (2) @(posedge clk);
    #1;

    checkOutput("wr_queue_left", wrAddrQ.size(), 0);
    checkOutput("rd_queue_left", rdAddrQ.size(), 0);
    checkOutput("rom_queue_left", romAddrQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
